mux_nin_pipe: RTL and testbench

//  Parametrised N-input, WIDTH-bit selector with a registered output and a valid/ready handshake.

---
 rtl/mux_nin_pipe.sv | 107 ++++++++++
 tb/tb_mux_nin_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nin_pipe.sv
// N-input, WIDTH-bit registered selector with a valid/ready handshake.
// A 2-entry skid buffer keeps one beat per cycle flowing under backpressure.
module mux_nin_pipe #(
  parameter int WIDTH    = 16,
  parameter int NUM_IN   = 10,
  parameter int SEL_W    = 5,
  parameter int ERRCNT_W = 8
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic [ERRCNT_W-1:0]     err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state;
  logic                rdy_q;
  logic [WIDTH-1:0]    main_data, skid_data;
  logic                main_err, skid_err;
  logic [ERRCNT_W-1:0] err_count_q;

  logic [WIDTH-1:0]    new_data;
  logic                new_err;
  logic                accept, pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    new_data = '0;
    new_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        new_data = data_in[k*WIDTH +: WIDTH];
        new_err  = 1'b0;
      end
    end
  end

  // rdy_q keeps in_ready low through reset and lets it rise on the first edge after release.
  assign in_ready  = rdy_q && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign data_out  = main_data;
  assign out_err   = main_err;
  assign err_count = err_count_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= EMPTY;
      rdy_q       <= 1'b0;
      main_data   <= '0;
      main_err    <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      err_count_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= new_data;
            main_err  <= new_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= new_data;
            main_err  <= new_err;
          end else if (accept) begin
            skid_data <= new_data;
            skid_err  <= new_err;
            state     <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase

      // Clear wins over a same-edge erroneous accept; the count saturates rather than wraps.
      if (err_clr) begin
        err_count_q <= '0;
      end else if (accept && new_err && (err_count_q != {ERRCNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_nin_pipe.sv
// Directed bench for mux_nin_pipe: a default instance plus a 4-bit-counter instance
// sharing all stimulus so counter saturation can be observed alongside normal traffic.
module tb_mux_nin_pipe;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 10;
  localparam int SEL_W  = 5;

  logic                    CLK;
  logic                    Reset_n;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid, out_ready, err_clr;
  logic                    in_ready, out_err, out_valid;
  logic [WIDTH-1:0]        data_out;
  logic [7:0]              err_count;
  logic                    s_in_ready, s_out_err, s_out_valid;
  logic [WIDTH-1:0]        s_data_out;
  logic [3:0]              s_err_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] vals [NUM_IN] = '{16'd34555, 16'd32489, 16'd545, 16'd13, 16'd6452,
                                     16'd789, 16'd564, 16'd4565, 16'd1, 16'd4575};

  mux_nin_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERRCNT_W(8)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .data_in(data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_count(err_count));

  mux_nin_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERRCNT_W(4)) dut_sat (
    .CLK(CLK), .Reset_n(Reset_n), .data_in(data_in), .sel(sel), .in_valid(in_valid),
    .in_ready(s_in_ready), .data_out(s_data_out), .out_err(s_out_err), .out_valid(s_out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_count(s_err_count));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = '0;
    for (int k = 0; k < NUM_IN; k++) data_in[k*WIDTH +: WIDTH] = vals[k];
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    checks++; if (data_out !== 16'd0) begin errors++; $display("FAIL rst_data_out got %0d exp 0", data_out); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
    tick;
    tick;
    Reset_n = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_out_valid got %0b exp 0", out_valid); end
  endtask

  task automatic test_select;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      sel = SEL_W'(i);
      tick;
      checks++;
      if (data_out !== vals[i] || out_err !== 1'b0 || out_valid !== 1'b1)
        begin errors++; $display("FAIL sel_beat sel=%0d got d=%0d e=%0b v=%0b exp d=%0d e=0 v=1",
                                 i, data_out, out_err, out_valid, vals[i]); end
    end
    in_valid = 1'b0;
    sel = 5'd3;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain_valid got %0b exp 0", out_valid); end
    checks++; if (data_out !== vals[9]) begin errors++; $display("FAIL sel_empty_hold got %0d exp %0d", data_out, vals[9]); end
  endtask

  task automatic test_out_of_range;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 10; i < 32; i++) begin
      sel = SEL_W'(i);
      tick;
      checks++;
      if (data_out !== 16'd0 || out_err !== 1'b1 || out_valid !== 1'b1)
        begin errors++; $display("FAIL oor_beat sel=%0d got d=%0d e=%0b v=%0b exp d=0 e=1 v=1",
                                 i, data_out, out_err, out_valid); end
    end
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd22) begin errors++; $display("FAIL oor_count got %0d exp 22", err_count); end
    checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL oor_count_sat got %0d exp 15", s_err_count); end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 5'd2;
    tick;
    checks++; if (data_out !== 16'd545 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_first got d=%0d r=%0b exp d=545 r=1", data_out, in_ready); end
    sel = 5'd3;
    tick;
    in_valid = 1'b0;
    sel = 5'd7;
    checks++; if (in_ready !== 1'b0 || data_out !== 16'd545 || out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_full got d=%0d r=%0b v=%0b exp d=545 r=0 v=1", data_out, in_ready, out_valid); end
    tick;
    checks++; if (data_out !== 16'd545 || in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_hold got d=%0d r=%0b exp d=545 r=0", data_out, in_ready); end
    out_ready = 1'b1;
    tick;
    checks++; if (data_out !== 16'd13 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_second got d=%0d v=%0b r=%0b exp d=13 v=1 r=1", data_out, out_valid, in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int beats;
    beats = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sel = SEL_W'(i % 10);
      tick;
      if (out_valid === 1'b1 && data_out === vals[i % 10]) beats++;
    end
    in_valid = 1'b0;
    checks++; if (beats !== 50) begin errors++; $display("FAIL b2b_beats got %0d exp 50", beats); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b exp 1", in_ready); end
    tick;
  endtask

  task automatic test_saturation;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    checks++; if (err_count !== 8'd0 || s_err_count !== 4'd0) begin errors++;
      $display("FAIL sat_clear got %0d/%0d exp 0/0", err_count, s_err_count); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 5'd15;
    for (int i = 0; i < 20; i++) tick;
    checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_stop got %0d exp 15", s_err_count); end
    checks++; if (err_count !== 8'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", err_count); end
    err_clr = 1'b1;
    tick;
    err_clr  = 1'b0;
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd0 || s_err_count !== 4'd0 || out_err !== 1'b1) begin errors++;
      $display("FAIL sat_clr_prio got %0d/%0d e=%0b exp 0/0 e=1", err_count, s_err_count, out_err); end
    tick;
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 5'd20;
    tick;
    sel = 5'd5;
    tick;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || err_count !== 8'd1) begin errors++;
      $display("FAIL mr_full got r=%0b c=%0d exp r=0 c=1", in_ready, err_count); end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || data_out !== 16'd0 || err_count !== 8'd0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL mr_async got v=%0b d=%0d c=%0d r=%0b exp 0/0/0/0", out_valid, data_out, err_count, in_ready); end
    tick;
    Reset_n = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL mr_release got r=%0b v=%0b exp r=1 v=0", in_ready, out_valid); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 5'd7;
    tick;
    in_valid = 1'b0;
    checks++; if (data_out !== 16'd4565 || out_valid !== 1'b1 || out_err !== 1'b0) begin errors++;
      $display("FAIL mr_first_beat got d=%0d v=%0b e=%0b exp d=4565 v=1 e=0", data_out, out_valid, out_err); end
    tick;
  endtask

  initial begin
    test_reset;
    test_select;
    test_out_of_range;
    test_backpressure;
    test_back_to_back;
    test_saturation;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
